// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
package irq_pkg;

    // Handshake FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    // Configuration write targets.
    localparam logic CFG_MASK = 1'b0;
    localparam logic CFG_CLR  = 1'b1;

endpackage : irq_pkg

// File: rtl/irq_sync.sv
// Two-flop synchroniser plus delay flop; flags a rising edge of one source.
module irq_sync
    import irq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic src,
    output logic rise_c
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic dly_q,   dly_d;

    // Next values for the synchroniser chain and delay stage.
    always_comb begin
        sync1_d = src;
        sync2_d = sync1_q;
        dly_d   = sync2_q;
    end

    // Synchroniser and delay registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dly_q   <= dly_d;
        end
    end

    assign rise_c = sync2_q & ~dly_q;

endmodule : irq_sync

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronised edge capture, pending/mask registers,
// lowest-index priority select and request/ack/return handshake with the PS.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned          NUM_IRQ  = 4,
    parameter int unsigned          VEC_W    = 2,
    parameter logic [NUM_IRQ-1:0]   MASK_RST = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               cfg_we,
    input  logic               cfg_sel,
    input  logic [NUM_IRQ-1:0] cfg_wdata,
    input  logic               ps_ack,
    input  logic               ps_rti,
    output logic               interrupt,
    output logic [VEC_W-1:0]   irq_vec,
    output logic [NUM_IRQ-1:0] irq_pend,
    output logic [NUM_IRQ-1:0] irq_mask,
    output logic               irq_busy
);

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] req;
    logic [VEC_W-1:0]   win;
    logic               ack_take;
    irq_state_e         state_q, state_d;
    logic               interrupt_q, interrupt_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic               busy_q, busy_d;

    // One synchroniser/edge detector per source.
    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
        irq_sync u_sync (
            .clk    (clk),
            .reset  (reset),
            .src    (irq_src[i]),
            .rise_c (rise[i])
        );
    end

    // Priority select: lowest index among enabled pending requests.
    always_comb begin
        req = pend_q & mask_q;
        win = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (req[i]) win = VEC_W'(i);
        end
    end

    // Pending and mask update; a fresh edge overrides any clear on the same bit.
    always_comb begin
        ack_take = (state_q == REQ) && ps_ack;
        pend_d   = pend_q;
        mask_d   = mask_q;
        if (cfg_we && (cfg_sel == CFG_CLR))  pend_d = pend_d & ~cfg_wdata;
        if (cfg_we && (cfg_sel == CFG_MASK)) mask_d = cfg_wdata;
        if (ack_take)                        pend_d[vec_q] = 1'b0;
        pend_d = pend_d | rise;
    end

    // Handshake FSM next state and registered outputs.
    always_comb begin
        state_d     = state_q;
        interrupt_d = interrupt_q;
        vec_d       = vec_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    vec_d       = win;
                    interrupt_d = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (ps_ack) begin
                    interrupt_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = SERVICE;
                end
            end
            SERVICE: begin
                if (ps_rti) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                interrupt_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            mask_q      <= MASK_RST;
            interrupt_q <= 1'b0;
            vec_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            interrupt_q <= interrupt_d;
            vec_q       <= vec_d;
            busy_q      <= busy_d;
        end
    end

    assign interrupt = interrupt_q;
    assign irq_vec   = vec_q;
    assign irq_pend  = pend_q;
    assign irq_mask  = mask_q;
    assign irq_busy  = busy_q;

endmodule : irq_ctrl

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: vector table, directed corner cases, random run vs model.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] src;
    logic       we, sel;
    logic [3:0] wd;
    logic       ack, rti;
    logic       d_int;
    logic [1:0] d_vec;
    logic [3:0] d_pend, d_mask;
    logic       d_busy;

    int checks = 0;
    int errors = 0;

    irq_ctrl #(.NUM_IRQ(4), .VEC_W(2), .MASK_RST(4'b0000)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .irq_src   (src),
        .cfg_we    (we),
        .cfg_sel   (sel),
        .cfg_wdata (wd),
        .ps_ack    (ack),
        .ps_rti    (rti),
        .interrupt (d_int),
        .irq_vec   (d_vec),
        .irq_pend  (d_pend),
        .irq_mask  (d_mask),
        .irq_busy  (d_busy)
    );

    always #5 clk = ~clk;

    // Reference model: src sample history (h1 newest), registers, handshake flags.
    logic [3:0] h1, h2, h3;
    logic [3:0] m_pend, m_mask;
    logic       m_int, m_busy;
    logic [1:0] m_vec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic idle_in();
        src = 4'b0; we = 1'b0; sel = 1'b0; wd = 4'b0; ack = 1'b0; rti = 1'b0; rst_n = 1'b1;
    endtask

    // Advance model by one edge using current inputs, clock DUT, compare all outputs.
    task automatic step();
        logic [3:0] req, rise, low, n_pend;
        if (!rst_n) begin
            h1 = '0; h2 = '0; h3 = '0;
            m_pend = '0; m_mask = 4'b0000; m_int = 0; m_busy = 0; m_vec = '0;
        end else begin
            rise = h2 & ~h3;
            req  = m_pend & m_mask;
            n_pend = m_pend;
            if (we && sel) n_pend = n_pend & ~wd;
            if (m_int && ack) n_pend[m_vec] = 1'b0;
            n_pend = n_pend | rise;
            if (we && !sel) m_mask = wd;
            if (m_int) begin
                if (ack) begin m_int = 0; m_busy = 1; end
            end else if (m_busy) begin
                if (rti) m_busy = 0;
            end else if (req != 0) begin
                low   = req & (~req + 4'd1);
                m_vec = 2'($clog2(low));
                m_int = 1;
            end
            m_pend = n_pend;
            h3 = h2; h2 = h1; h1 = src;
        end
        @(posedge clk);
        #1;
        chk("model_int",  32'(d_int),  32'(m_int));
        chk("model_vec",  32'(d_vec),  32'(m_vec));
        chk("model_pend", 32'(d_pend), 32'(m_pend));
        chk("model_mask", 32'(d_mask), 32'(m_mask));
        chk("model_busy", 32'(d_busy), 32'(m_busy));
    endtask

    // Step until interrupt rises, bounded.
    task automatic wait_int(input int max_cyc);
        int n = 0;
        while (d_int !== 1'b1 && n < max_cyc) begin
            step();
            n++;
        end
        chk("wait_int_timeout", 32'(d_int), 32'd1);
    endtask

    task automatic pulse(input logic [3:0] bits);
        src = bits; step(); src = 4'b0;
    endtask

    typedef struct {
        logic [3:0] src;
        logic       we;
        logic       sel;
        logic [3:0] wd;
        logic       ack;
        logic       rti;
        logic       e_int;
        logic [1:0] e_vec;
        logic [3:0] e_pend;
        logic [3:0] e_mask;
        logic       e_busy;
    } row_t;

    row_t tbl[19];

    initial begin
        int ints, sets;
        logic prev_int, prev_p0;

        //            src   we sel wd    ack rti  int vec pend  mask  busy
        tbl[0]  = '{4'h4, 0, 0, 4'h0, 0, 0,  0, 0, 4'h0, 4'h0, 0};
        tbl[1]  = '{4'h0, 0, 0, 4'h0, 0, 0,  0, 0, 4'h0, 4'h0, 0};
        tbl[2]  = '{4'h0, 0, 0, 4'h0, 0, 0,  0, 0, 4'h4, 4'h0, 0};
        tbl[3]  = '{4'h0, 0, 0, 4'h0, 0, 0,  0, 0, 4'h4, 4'h0, 0};
        tbl[4]  = '{4'h0, 1, 0, 4'h4, 0, 0,  0, 0, 4'h4, 4'h4, 0};
        tbl[5]  = '{4'h0, 0, 0, 4'h0, 0, 0,  1, 2, 4'h4, 4'h4, 0};
        tbl[6]  = '{4'h0, 0, 0, 4'h0, 1, 0,  0, 2, 4'h0, 4'h4, 1};
        tbl[7]  = '{4'h0, 0, 0, 4'h0, 0, 1,  0, 2, 4'h0, 4'h4, 0};
        tbl[8]  = '{4'h0, 1, 0, 4'hF, 0, 0,  0, 2, 4'h0, 4'hF, 0};
        tbl[9]  = '{4'hA, 0, 0, 4'h0, 0, 0,  0, 2, 4'h0, 4'hF, 0};
        tbl[10] = '{4'hA, 0, 0, 4'h0, 0, 0,  0, 2, 4'h0, 4'hF, 0};
        tbl[11] = '{4'hA, 0, 0, 4'h0, 0, 0,  0, 2, 4'hA, 4'hF, 0};
        tbl[12] = '{4'h0, 0, 0, 4'h0, 0, 0,  1, 1, 4'hA, 4'hF, 0};
        tbl[13] = '{4'h0, 0, 0, 4'h0, 1, 0,  0, 1, 4'h8, 4'hF, 1};
        tbl[14] = '{4'h0, 0, 0, 4'h0, 0, 0,  0, 1, 4'h8, 4'hF, 1};
        tbl[15] = '{4'h0, 0, 0, 4'h0, 0, 1,  0, 1, 4'h8, 4'hF, 0};
        tbl[16] = '{4'h0, 0, 0, 4'h0, 0, 0,  1, 3, 4'h8, 4'hF, 0};
        tbl[17] = '{4'h0, 0, 0, 4'h0, 1, 1,  0, 3, 4'h0, 4'hF, 1};
        tbl[18] = '{4'h0, 0, 0, 4'h0, 0, 1,  0, 3, 4'h0, 4'hF, 0};

        // Reset state.
        idle_in();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_int",  32'(d_int),  32'd0);
        chk("rst_pend", 32'(d_pend), 32'd0);
        chk("rst_mask", 32'(d_mask), 32'd0);
        chk("rst_busy", 32'(d_busy), 32'd0);

        // Vector table: masked pend, unmask raise, priority, back-to-back, ack+rti.
        for (int i = 0; i < 19; i++) begin
            src = tbl[i].src; we = tbl[i].we; sel = tbl[i].sel; wd = tbl[i].wd;
            ack = tbl[i].ack; rti = tbl[i].rti;
            step();
            chk($sformatf("tbl%0d_int", i),  32'(d_int),  32'(tbl[i].e_int));
            chk($sformatf("tbl%0d_vec", i),  32'(d_vec),  32'(tbl[i].e_vec));
            chk($sformatf("tbl%0d_pend", i), 32'(d_pend), 32'(tbl[i].e_pend));
            chk($sformatf("tbl%0d_mask", i), 32'(d_mask), 32'(tbl[i].e_mask));
            chk($sformatf("tbl%0d_busy", i), 32'(d_busy), 32'(tbl[i].e_busy));
        end
        idle_in();

        // Mask cleared while in REQ: request and vector hold.
        pulse(4'b0001);
        wait_int(10);
        chk("req_vec0", 32'(d_vec), 32'd0);
        we = 1; sel = 0; wd = 4'h0; step(); idle_in();
        chk("req_hold_int", 32'(d_int), 32'd1);
        step();
        chk("req_hold_int2", 32'(d_int), 32'd1);
        chk("req_hold_vec",  32'(d_vec), 32'd0);
        ack = 1; step(); idle_in();
        chk("ack_clr_pend0", 32'(d_pend[0]), 32'd0);
        chk("ack_busy",      32'(d_busy),    32'd1);
        rti = 1; step(); idle_in();
        we = 1; wd = 4'hF; step(); idle_in();

        // Spurious rti in IDLE.
        rti = 1; step(); idle_in();
        chk("spur_rti_busy", 32'(d_busy), 32'd0);
        chk("spur_rti_int",  32'(d_int),  32'd0);

        // Edge set coincident with ack clear on the same bit.
        pulse(4'b0010);
        wait_int(10);
        chk("setwin_vec", 32'(d_vec), 32'd1);
        src = 4'b0010; step(); idle_in();
        step();
        ack = 1; step(); idle_in();
        chk("setwin_pend", 32'(d_pend), 32'h2);
        chk("setwin_busy", 32'(d_busy), 32'd1);
        ack = 1; step(); idle_in();
        chk("spur_ack_busy", 32'(d_busy), 32'd1);
        chk("spur_ack_int",  32'(d_int),  32'd0);
        rti = 1; step(); idle_in();
        step();
        chk("reraise_int", 32'(d_int), 32'd1);
        chk("reraise_vec", 32'(d_vec), 32'd1);
        ack = 1; step(); idle_in();
        rti = 1; step(); idle_in();

        // Cfg clear of a masked pending bit.
        we = 1; wd = 4'h0; step(); idle_in();
        pulse(4'b0100);
        step(); step();
        chk("cfgclr_pre", 32'(d_pend), 32'h4);
        we = 1; sel = 1; wd = 4'h4; step(); idle_in();
        chk("cfgclr_post", 32'(d_pend), 32'h0);
        we = 1; wd = 4'hF; step(); idle_in();

        // Level held high for 20 cycles: single pend set, single interrupt.
        ints = 0; sets = 0; prev_int = d_int; prev_p0 = d_pend[0];
        for (int i = 0; i < 26; i++) begin
            src = (i < 20) ? 4'b0001 : 4'b0000;
            ack = d_int;
            rti = d_busy;
            step();
            if (d_int && !prev_int) ints++;
            if (d_pend[0] && !prev_p0) sets++;
            prev_int = d_int; prev_p0 = d_pend[0];
        end
        idle_in();
        chk("level_one_int", 32'(ints), 32'd1);
        chk("level_one_set", 32'(sets), 32'd1);

        // Reset during SERVICE.
        pulse(4'b1000);
        wait_int(10);
        ack = 1; step(); idle_in();
        chk("svc_busy", 32'(d_busy), 32'd1);
        rst_n = 0; step(); idle_in();
        chk("svcrst_int",  32'(d_int),  32'd0);
        chk("svcrst_busy", 32'(d_busy), 32'd0);
        chk("svcrst_pend", 32'(d_pend), 32'd0);
        chk("svcrst_mask", 32'(d_mask), 32'd0);
        step();
        chk("svcrst_idle", 32'(d_int), 32'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) src = src ^ 4'($urandom_range(0, 15));
            we  = ($urandom_range(0, 15) == 0);
            sel = 1'($urandom_range(0, 1));
            wd  = 4'($urandom_range(0, 15));
            ack = ($urandom_range(0, 3) == 0);
            rti = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            step();
        end
        idle_in();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_irq_ctrl
